// File: rtl/multi_edge_detect_if.sv
// Signal bundle for multi_edge_detect: monitored lines, mode/clear controls,
// edge pulses, sticky flags and the saturating event counter.
interface multi_edge_detect_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] x;
  logic [1:0]       mode;
  logic             clr;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] flag;
  logic [CNT_W-1:0] edge_cnt;

  modport master (
    output x, mode, clr,
    input  y, flag, edge_cnt
  );

  modport slave (
    input  x, mode, clr,
    output y, flag, edge_cnt
  );
endinterface

// File: rtl/multi_edge_detect.sv
// Multi-channel Moore edge detector with sticky flags and a saturating event
// counter. Define EDGE_SYNC_EN to insert a two-flop synchroniser on every x bit.
module multi_edge_detect #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic                clk,
  input logic                reset,
  multi_edge_detect_if.slave bus
);

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_RISE = 2'b01,
    S_HIGH = 2'b10,
    S_FALL = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    M_RISE = 2'b00,
    M_FALL = 2'b01,
    M_BOTH = 2'b10,
    M_OFF  = 2'b11
  } mode_t;

  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [WIDTH-1:0] xs;
  state_t           st    [WIDTH];
  state_t           st_nx [WIDTH];
  mode_t            mode_q;
  logic [WIDTH-1:0] y_int;
  logic [WIDTH-1:0] flag_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   pop;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] cnt_nx;

`ifdef EDGE_SYNC_EN
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.x;
      sync2 <= sync1;
    end
  end

  assign xs = sync2;
`else
  assign xs = bus.x;
`endif

  // Reset seeds each channel from its current level so release never looks like an edge.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (reset) st[i] <= xs[i] ? S_HIGH : S_LOW;
      else       st[i] <= st_nx[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      st_nx[i] = st[i];
      unique case (st[i])
        S_LOW:  st_nx[i] = xs[i] ? S_RISE : S_LOW;
        S_RISE: st_nx[i] = xs[i] ? S_HIGH : S_FALL;
        S_HIGH: st_nx[i] = xs[i] ? S_HIGH : S_FALL;
        S_FALL: st_nx[i] = xs[i] ? S_RISE : S_LOW;
        default: st_nx[i] = S_LOW;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) mode_q <= M_RISE;
    else       mode_q <= mode_t'(bus.mode);
  end

  always_comb begin
    y_int = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      unique case (st[i])
        S_RISE:  y_int[i] = (mode_q == M_RISE) || (mode_q == M_BOTH);
        S_FALL:  y_int[i] = (mode_q == M_FALL) || (mode_q == M_BOTH);
        default: y_int[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop = pop + {{CNT_W{1'b0}}, y_int[i]};
    end
    sum    = {1'b0, cnt_q} + pop;
    cnt_nx = (sum > CNT_MAX) ? '1 : sum[CNT_W-1:0];
  end

  // clr wins over same-cycle pulse activity; FSMs are deliberately untouched.
  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      flag_q <= '0;
      cnt_q  <= '0;
    end else begin
      flag_q <= flag_q | y_int;
      cnt_q  <= cnt_nx;
    end
  end

  assign bus.y        = y_int;
  assign bus.flag     = flag_q;
  assign bus.edge_cnt = cnt_q;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Self-checking bench for multi_edge_detect (WIDTH=4, CNT_W=4): directed steps
// and random traffic checked against a sampled-level transition model.
module tb_multi_edge_detect;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 4;

  logic clk;
  logic reset;

  multi_edge_detect_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  multi_edge_detect #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int fails = 0;

  // Model: an edge is a change between the two most recent levels the FSMs saw.
  logic [W-1:0] xp, xc, ye, fe;
  logic [W-1:0] s1m, s2m;
  logic [1:0]   mq;
  int           cnte;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [W-1:0] nx, input logic [1:0] nmode,
                      input logic nclr, input logic nrst, input logic do_chk);
    logic [W-1:0] fin;
    bus.x    = nx;
    bus.mode = nmode;
    bus.clr  = nclr;
    reset    = nrst;
    @(posedge clk);
`ifdef EDGE_SYNC_EN
    fin = s2m;
    if (nrst) begin
      s1m = '0;
      s2m = '0;
    end else begin
      s2m = s1m;
      s1m = nx;
    end
`else
    fin = nx;
`endif
    if (nrst) begin
      fe = '0; cnte = 0; mq = 2'b00;
      xp = fin; xc = fin;
    end else begin
      if (nclr) begin
        fe = '0; cnte = 0;
      end else begin
        fe = fe | ye;
        cnte = cnte + $countones(ye);
        if (cnte > 15) cnte = 15;
      end
      mq = nmode;
      xp = xc;
      xc = fin;
    end
    ye = '0;
    if (mq == 2'b00 || mq == 2'b10) ye = ye | (xc & ~xp);
    if (mq == 2'b01 || mq == 2'b10) ye = ye | (~xc & xp);
    #1;
    if (do_chk) begin
      chk("y", 32'(bus.y), 32'(ye));
      chk("flag", 32'(bus.flag), 32'(fe));
      chk("edge_cnt", 32'(bus.edge_cnt), 32'(cnte));
    end
  endtask

  int pulses;

  initial begin
    xp = '0; xc = '0; ye = '0; fe = '0; s1m = '0; s2m = '0; mq = '0; cnte = 0;
    bus.x = '0; bus.mode = '0; bus.clr = 1'b0; reset = 1'b1;

    // x[0] high through reset, then 1->0->1 in rising mode
    step(4'b0001, 2'b00, 1'b0, 1'b1, 1'b0);
    step(4'b0001, 2'b00, 1'b0, 1'b1, 1'b0);
    step(4'b0001, 2'b00, 1'b0, 1'b1, 1'b1);
    step(4'b0001, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("no_pulse_at_release", 32'(bus.y), 32'h0);
    step(4'b0000, 2'b00, 1'b0, 1'b0, 1'b1);
    step(4'b0001, 2'b00, 1'b0, 1'b0, 1'b1);
`ifndef EDGE_SYNC_EN
    chk("rise_pulse_y0", 32'(bus.y), 32'h1);
`endif
    step(4'b0001, 2'b00, 1'b0, 1'b0, 1'b1);
    step(4'b0001, 2'b00, 1'b0, 1'b0, 1'b1);
    step(4'b0001, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("cnt_after_one_rise", 32'(bus.edge_cnt), 32'h1);

    // Both-edge mode, all channels 0->F->0
    step(4'b0000, 2'b00, 1'b0, 1'b1, 1'b1);
    step(4'b1111, 2'b10, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 2'b10, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 2'b10, 1'b0, 1'b0, 1'b1);
`ifndef EDGE_SYNC_EN
    chk("both_cnt8", 32'(bus.edge_cnt), 32'd8);
    chk("both_flagF", 32'(bus.flag), 32'hF);
`endif

    // Falling mode, period-4 square wave on x[2]
    step(4'b0000, 2'b01, 1'b0, 1'b1, 1'b1);
    pulses = 0;
    for (int i = 0; i < 19; i++) begin
      step((i < 16 && ((i / 2) % 2) == 1) ? 4'b0100 : 4'b0000, 2'b01, 1'b0, 1'b0, 1'b1);
      if (bus.y[2]) pulses++;
    end
    chk("fall_pulse_count", 32'(pulses), 32'd4);
    chk("fall_only_ch2", 32'(bus.flag), 32'h4);

    // Saturation and clr-priority
    step(4'b0000, 2'b10, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++)
      step((i % 2) == 0 ? 4'b1111 : 4'b0000, 2'b10, 1'b0, 1'b0, 1'b1);
    chk("cnt_saturated", 32'(bus.edge_cnt), 32'd15);
    step(4'b1111, 2'b10, 1'b0, 1'b0, 1'b1);
    chk("cnt_holds_max", 32'(bus.edge_cnt), 32'd15);
    step(4'b0000, 2'b10, 1'b1, 1'b0, 1'b1);
    chk("clr_cnt", 32'(bus.edge_cnt), 32'd0);
    chk("clr_flag", 32'(bus.flag), 32'd0);

    // Disabled mode, then re-enable as x[1] rises; reset mid-pulse
    step(4'b0000, 2'b11, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      step((i % 2) == 0 ? 4'b1111 : 4'b0000, 2'b11, 1'b0, 1'b0, 1'b1);
    chk("disabled_flag", 32'(bus.flag), 32'h0);
    chk("disabled_cnt", 32'(bus.edge_cnt), 32'h0);
    step(4'b0010, 2'b00, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 2'b00, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 2'b00, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 2'b10, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 2'b10, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 2'b10, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 2'b10, 1'b0, 1'b1, 1'b1);
    chk("reset_kills_pulse", 32'(bus.y), 32'h0);

`ifdef EDGE_SYNC_EN
    // Synchronised latency: single 0->1 on x[3]
    step(4'b0000, 2'b00, 1'b0, 1'b1, 1'b1);
    step(4'b0000, 2'b00, 1'b0, 1'b1, 1'b1);
    step(4'b0000, 2'b00, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 2'b00, 1'b0, 1'b0, 1'b1);
    step(4'b1000, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("sync_lat1", 32'(bus.y), 32'h0);
    step(4'b1000, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("sync_lat2", 32'(bus.y), 32'h0);
    step(4'b1000, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("sync_lat3", 32'(bus.y), 32'h8);
`endif

    // Random traffic
    step(4'b0000, 2'b00, 1'b0, 1'b1, 1'b1);
    step(4'b0000, 2'b00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 400; i++)
      step(4'($urandom), 2'($urandom), ($urandom_range(15) == 0),
           ($urandom_range(39) == 0), 1'b1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
